// File: rtl/ssd1306_fb_streamer.sv
// ssd1306_fb_streamer: streams a 128x64 framebuffer to an SSD1306 over an I2C byte master.
// Sends the addressing command transaction, then one data transaction carrying every framebuffer byte.
module ssd1306_fb_streamer #(
    parameter logic [6:0] I2C_ADDR = 7'h3C,
    parameter int         FB_BYTES = 1024
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic       gfx_ready,
    output logic [9:0] fb_addr,
    output logic       fb_rd,
    input  logic [7:0] fb_data,
    output logic [7:0] tx_data,
    output logic       tx_start,
    output logic       tx_stop,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       done
);
    localparam int AW = $clog2(FB_BYTES);

    typedef enum logic [2:0] {IDLE, WAIT_GFX, CMD, DHDR, FETCH, LATCH, DATA, FIN} state_t;

    state_t        state, state_next;
    logic [2:0]    idx;
    logic [AW-1:0] n;
    logic [7:0]    hold;
    logic [7:0]    cmd_byte;
    logic          accept;
    logic          last_n;

    assign accept = tx_valid && tx_ready;
    assign last_n = n == AW'(FB_BYTES - 1);

    // idx walks the bytes of the command and data-header transactions; it restarts on every state change
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            idx   <= '0;
            n     <= '0;
            hold  <= '0;
        end else begin
            state <= state_next;
            idx   <= (state_next != state) ? 3'd0 : accept ? idx + 3'd1 : idx;
            if (state == DHDR)
                n <= '0;
            else if (state == DATA && accept && !last_n)
                n <= n + AW'(1);
            if (state == LATCH)
                hold <= fb_data;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     state_next = start ? WAIT_GFX : IDLE;
            WAIT_GFX: state_next = gfx_ready ? CMD : WAIT_GFX;
            CMD:      state_next = (accept && idx == 3'd7) ? DHDR : CMD;
            DHDR:     state_next = (accept && idx == 3'd1) ? FETCH : DHDR;
            FETCH:    state_next = LATCH;
            LATCH:    state_next = DATA;
            DATA:     state_next = accept ? (last_n ? FIN : FETCH) : DATA;
            FIN:      state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // all outputs decode from registered state, so they hold steady while a byte waits for acceptance
    always_comb begin
        cmd_byte = idx == 3'd0 ? {I2C_ADDR, 1'b0} :
                   idx == 3'd2 ? 8'h21 :
                   idx == 3'd4 ? 8'h7F :
                   idx == 3'd5 ? 8'h22 :
                   idx == 3'd7 ? 8'h07 : 8'h00;
        tx_valid = state == CMD || state == DHDR || state == DATA;
        tx_data  = state == CMD  ? cmd_byte :
                   state == DHDR ? (idx == 3'd0 ? {I2C_ADDR, 1'b0} : 8'h40) :
                   state == DATA ? hold : 8'h00;
        tx_start = (state == CMD || state == DHDR) && idx == 3'd0;
        tx_stop  = (state == CMD && idx == 3'd7) || (state == DATA && last_n);
        fb_rd    = state == FETCH;
        fb_addr  = fb_rd ? 10'(n) : 10'd0;
        busy     = state != IDLE;
        done     = state == FIN;
    end
endmodule

// File: doc/ssd1306_fb_streamer.md
SSD1306_FB_STREAMER -- requirements
Module: ssd1306_fb_streamer

Interface
REQ-001 Parameter I2C_ADDR, default 7'h3C, SHALL set the 7-bit SSD1306 slave address; the write-address byte is {I2C_ADDR,1'b0}.
REQ-002 Parameter FB_BYTES, default 1024, SHALL set the number of framebuffer bytes streamed per frame (128x64/8).
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 resetn  in  1  asynchronous active-low reset.
REQ-005 start  in  1  request one full-frame refresh; acted on only in IDLE.
REQ-006 gfx_ready  in  1  high when the renderer is idle; the streamer SHALL NOT read the framebuffer while it is low.
REQ-007 fb_addr  out  10  framebuffer byte address, page-major: addr = page*128 + column.
REQ-008 fb_rd  out  1  framebuffer read enable; also selects the streamer's address at the framebuffer read port.
REQ-009 fb_data  in  8  framebuffer read data, valid exactly 1 cycle after fb_rd with fb_addr.
REQ-010 tx_data  out  8  byte for the I2C byte master.
REQ-011 tx_start  out  1  this byte is the first byte of an I2C transaction (START before it).
REQ-012 tx_stop  out  1  this byte is the last byte of an I2C transaction (STOP after it).
REQ-013 tx_valid  out  1  byte offered; tx_ready  in  1  byte accepted when tx_valid && tx_ready.
REQ-014 busy  out  1  high in every state except IDLE; done  out  1  one-cycle pulse at frame end.

Function
REQ-015 States SHALL be IDLE, WAIT_GFX, CMD, DHDR, FETCH, LATCH, DATA, FIN.
REQ-016 IDLE: on start=1 -> WAIT_GFX; otherwise remain, all outputs low.
REQ-017 WAIT_GFX: remain while gfx_ready=0; when gfx_ready=1 -> CMD.
REQ-018 CMD SHALL send one transaction of 8 bytes: {I2C_ADDR,0}, 0x00, 0x21, 0x00, 0x7F, 0x22, 0x00, 0x07; tx_start on byte 0 only, tx_stop on byte 7 only; then -> DHDR.
REQ-019 DHDR SHALL send {I2C_ADDR,0} with tx_start=1, then 0x40, both tx_stop=0; then -> FETCH with byte counter n=0.
REQ-020 FETCH: fb_rd=1, fb_addr=n for one cycle -> LATCH.
REQ-021 LATCH: capture fb_data into a holding register -> DATA.
REQ-022 DATA: tx_data=holding register, tx_start=0, tx_stop=1 iff n==FB_BYTES-1; on acceptance: if n==FB_BYTES-1 -> FIN, else n<=n+1 -> FETCH.
REQ-023 FIN: done=1 for exactly one cycle -> IDLE.
REQ-024 Handshake: once tx_valid rises, tx_data, tx_start, tx_stop SHALL remain stable and tx_valid high until accepted; tx_valid SHALL deassert the cycle after acceptance unless the next byte is immediately available.
REQ-025 Byte counter SHALL be 10 bits (clog2(FB_BYTES)); no wrap beyond FB_BYTES-1 within a frame.
REQ-026 fb_rd SHALL be high only in FETCH; fb_addr SHALL be 0 when fb_rd is low.
REQ-027 start asserted while busy=1 SHALL be ignored (not queued).
REQ-028 gfx_ready falling after WAIT_GFX SHALL NOT stall the stream; the frame completes with whatever data the framebuffer returns.
REQ-029 tx_ready held low indefinitely SHALL hold the current byte with no timeout.
REQ-030 Simultaneous done and start (FIN cycle) SHALL ignore start; a new start is accepted in IDLE from the next cycle.

Reset
REQ-031 resetn=0 SHALL immediately force state IDLE, n=0, holding register 0, and busy, done, fb_rd, tx_valid, tx_start, tx_stop, tx_data, fb_addr all 0, including mid-transaction.
REQ-032 After reset release the block SHALL take no action until a start is sampled high in IDLE.

Verification
REQ-033 Reset, start pulse, gfx_ready=1, tx_ready=1 always -> byte stream 78 00 21 00 7F 22 00 07 (start on 78, stop on 07), then 78 40 (start on 78), then 1024 framebuffer bytes with stop on the last, one done pulse.
REQ-034 Framebuffer preloaded with fb[a]=a[7:0]^a[9:8] -> data byte k equals fb[k] for k=0..1023, fb_rd high only one cycle per byte.
REQ-035 gfx_ready=0 for 50 cycles after start -> no tx_valid and no fb_rd until gfx_ready=1, then normal stream.
REQ-036 tx_ready randomly toggled (~30% duty) -> tx_data/tx_start/tx_stop stable while tx_valid && !tx_ready; identical byte sequence to REQ-033.
REQ-037 Second start during byte 500 -> ignored; exactly one done; start after done -> second full frame.
REQ-038 resetn low during data byte 300 -> all outputs 0 within the reset assertion; after release, start -> full frame from command byte 0.
